// File: rtl/keypad_scanner.sv
// keypad_scanner
//
// Scans a 4x3 matrix keypad one column at a time, synchronizes the active-low row
// inputs, assembles a full 12-key frame every three columns and debounces whole
// frames. Each accepted press is reported once as a one-hot code with a one-cycle
// valid strobe. Releases, bounces and multi-key frames are never reported.
//
// Key map: row r / column c -> bit 3r+c.
//   bits 0-8 = '1'-'9', bit 9 = '*', bit 10 = '0', bit 11 = '#'.
//
// Parameters
//   SCAN_CNT        cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS  identical consecutive frames needed to accept a press/release (>= 1)
//
// Ports
//   clk        single clock
//   rst        synchronous, active-high reset
//   key_row    keypad rows, active-low, asynchronous to clk
//   key_col    column drive, active-low, exactly one bit low
//   scan_data  one-hot code of the last reported key, held until the next report
//   valid      one-cycle pulse marking a new scan_data

module keypad_scanner #(
   parameter int unsigned SCAN_CNT       = 1024,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  key_row,
   output logic [2:0]  key_col,
   output logic [11:0] scan_data,
   output logic        valid
);

   localparam int unsigned DwellW  = $clog2(SCAN_CNT);
   localparam int unsigned StableW = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [DwellW-1:0]  DwellLast = DwellW'(SCAN_CNT - 1);
   localparam logic [StableW-1:0] StableMax = StableW'(DEBOUNCE_SCANS);

   typedef enum logic {
      StWaitPress,
      StWaitRelease
   } state_e;

   // Row synchronizer
   logic [3:0]  row_meta_q;
   logic [3:0]  row_sync_q;
   logic [3:0]  pressed;

   // Column scan
   logic [DwellW-1:0] dwell_q;
   logic [1:0]        col_q;
   logic [1:0]        col_next;
   logic [2:0]        key_col_q;
   logic              sample;
   logic              frame_end;

   // Frame assembly and debounce
   logic [11:0]        acc_q;
   logic [11:0]        acc_d;
   logic [11:0]        frame_code;
   logic [11:0]        prev_code_q;
   logic [StableW-1:0] stable_q;
   logic [StableW-1:0] stable_d;

   // Report FSM and registered outputs
   state_e      state_q;
   logic [11:0] scan_data_q;
   logic        valid_q;

   assign pressed = ~row_sync_q;

   // Sampling on the last dwell cycle gives the synchronizer at least two cycles to
   // carry the row response to the newly driven column.
   assign sample    = (dwell_q == DwellLast);
   assign frame_end = sample && (col_q == 2'd2);
   assign col_next  = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;

   // Drop the current column's four row bits into their slots of the frame.
   always_comb begin
      acc_d = acc_q;
      if (sample) begin
         case (col_q)
            2'd0:    {acc_d[9],  acc_d[6], acc_d[3], acc_d[0]} = pressed;
            2'd1:    {acc_d[10], acc_d[7], acc_d[4], acc_d[1]} = pressed;
            2'd2:    {acc_d[11], acc_d[8], acc_d[5], acc_d[2]} = pressed;
            default: ;
         endcase
      end
   end

   // Exactly one key down yields its code; none or several both read as "no key".
   always_comb begin
      frame_code = 12'h000;
      if ((acc_d != 12'h000) && ((acc_d & (acc_d - 12'd1)) == 12'h000)) begin
         frame_code = acc_d;
      end
   end

   always_comb begin
      if (frame_code == prev_code_q) begin
         stable_d = (stable_q == StableMax) ? stable_q : stable_q + 1'b1;
      end else begin
         stable_d = StableW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta_q  <= 4'h0;
         row_sync_q  <= 4'h0;
         dwell_q     <= '0;
         col_q       <= 2'd0;
         key_col_q   <= 3'b110;
         acc_q       <= 12'h000;
         prev_code_q <= 12'h000;
         stable_q    <= '0;
         state_q     <= StWaitPress;
         scan_data_q <= 12'h000;
         valid_q     <= 1'b0;
      end else begin
         row_meta_q <= key_row;
         row_sync_q <= row_meta_q;

         if (sample) begin
            dwell_q   <= '0;
            col_q     <= col_next;
            key_col_q <= ~(3'b001 << col_next);
         end else begin
            dwell_q <= dwell_q + 1'b1;
         end

         acc_q   <= acc_d;
         valid_q <= 1'b0;

         if (frame_end) begin
            prev_code_q <= frame_code;
            stable_q    <= stable_d;

            case (state_q)
               StWaitPress: begin
                  if ((stable_d == StableMax) && (frame_code != 12'h000)) begin
                     scan_data_q <= frame_code;
                     valid_q     <= 1'b1;
                     state_q     <= StWaitRelease;
                  end
               end
               StWaitRelease: begin
                  // A different key while still held (rollover) is ignored; only a
                  // debounced all-released frame re-arms the reporter.
                  if ((stable_d == StableMax) && (frame_code == 12'h000)) begin
                     state_q <= StWaitPress;
                  end
               end
               default: state_q <= StWaitPress;
            endcase
         end
      end
   end

   assign key_col   = key_col_q;
   assign scan_data = scan_data_q;
   assign valid     = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner with SCAN_CNT=4, DEBOUNCE_SCANS=3 (12-cycle frames).
// A small keypad model pulls a row low while a pressed key's column is driven.

module tb_keypad_scanner;

   localparam int unsigned ScanCnt  = 4;
   localparam int unsigned Debounce = 3;

   logic        clk;
   logic        rst;
   logic [3:0]  key_row;
   logic [2:0]  key_col;
   logic [11:0] scan_data;
   logic        valid;

   logic [11:0] keys;

   int n_checks = 0;
   int n_pass   = 0;
   int pulses   = 0;

   keypad_scanner #(
      .SCAN_CNT       (ScanCnt),
      .DEBOUNCE_SCANS (Debounce)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_row   (key_row),
      .key_col   (key_col),
      .scan_data (scan_data),
      .valid     (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Row r reads low when any pressed key in that row sits on the driven column.
   always_comb begin
      key_row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         key_row[r] = ~|(keys[3*r +: 3] & ~key_col);
      end
   end

   // Counts cycles with valid high, so a stretched pulse shows up as extra counts.
   always @(posedge clk) begin
      if (valid === 1'b1) pulses <= pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns at the negedge right after the last reset edge.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // k = negedges waited until valid is seen (0 = now), -1 on timeout.
   task automatic wait_valid(input int max, output int k);
      k = -1;
      for (int i = 0; i <= max; i++) begin
         if (i > 0) @(negedge clk);
         if (valid === 1'b1) begin
            k = i;
            break;
         end
      end
   endtask

   initial begin
      int k;
      int p0;
      logic [2:0] exp_col;

      rst  = 1'b1;
      keys = 12'h000;

      // Reset state and column drive with no keys pressed
      do_reset();
      check("rst_key_col", 32'(key_col), 32'h6);
      check("rst_scan_data", 32'(scan_data), 32'h000);
      check("rst_valid", 32'(valid), 32'h0);
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) @(negedge clk);
         exp_col = (c < 4) ? 3'b110 : (c < 8) ? 3'b101 : (c < 12) ? 3'b011 : 3'b110;
         check("col_drive", 32'(key_col), 32'(exp_col));
      end
      repeat (60) @(negedge clk);
      check("idle_pulses", pulses, 0);
      check("idle_scan_data", 32'(scan_data), 32'h000);

      // Single press of '5': three frames of 12 cycles from reset
      do_reset();
      keys = 12'h010;
      wait_valid(48, k);
      check("single_latency", k, 36);
      check("single_data", 32'(scan_data), 32'h010);
      @(negedge clk);
      check("single_width", 32'(valid), 32'h0);
      p0 = pulses;
      check("single_count", p0, 1);
      repeat (200) @(negedge clk);
      check("single_hold", pulses - p0, 0);
      keys = 12'h000;
      repeat (60) @(negedge clk);

      // Full map sweep
      p0 = pulses;
      for (int i = 0; i < 12; i++) begin
         keys = 12'(1 << i);
         wait_valid(80, k);
         check("sweep_data", 32'(scan_data), 32'd1 << i);
         keys = 12'h000;
         repeat (60) @(negedge clk);
      end
      check("sweep_count", pulses - p0, 12);

      // Bounce on '1': toggling every 5 cycles never yields three equal nonzero frames,
      // then the held key is accepted on the third stable frame (edge 96 after reset).
      do_reset();
      p0 = pulses;
      for (int s = 0; s < 12; s++) begin
         keys = (s % 2 == 0) ? 12'h001 : 12'h000;
         repeat (5) @(negedge clk);
      end
      keys = 12'h001;
      check("bounce_quiet", pulses - p0, 0);
      wait_valid(60, k);
      check("bounce_latency", k, 36);
      check("bounce_data", 32'(scan_data), 32'h001);
      keys = 12'h000;
      repeat (60) @(negedge clk);

      // Two keys together read as no key
      p0 = pulses;
      keys = 12'h101;
      repeat (100) @(negedge clk);
      check("multi_none", pulses - p0, 0);
      keys = 12'h000;
      repeat (60) @(negedge clk);

      // Rollover: '2' reported, '3' ignored until a full release and re-press
      keys = 12'h002;
      wait_valid(80, k);
      check("roll_seen", 32'(k >= 0), 32'h1);
      check("roll_first", 32'(scan_data), 32'h002);
      keys = 12'h006;
      repeat (8) @(negedge clk);
      keys = 12'h004;
      p0 = pulses;
      repeat (100) @(negedge clk);
      check("roll_ignored", pulses - p0, 0);
      check("roll_held_data", 32'(scan_data), 32'h002);
      keys = 12'h000;
      repeat (60) @(negedge clk);
      keys = 12'h004;
      wait_valid(80, k);
      check("roll_repress", 32'(scan_data), 32'h004);
      keys = 12'h000;
      repeat (60) @(negedge clk);

      // Reset during the 2nd stable frame of a '7' press
      do_reset();
      keys = 12'h040;
      repeat (18) @(negedge clk);
      check("mid_col_before", 32'(key_col), 32'h5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_key_col", 32'(key_col), 32'h6);
      check("mid_scan_data", 32'(scan_data), 32'h000);
      check("mid_valid", 32'(valid), 32'h0);
      wait_valid(48, k);
      check("mid_latency", k, 36);
      check("mid_data", 32'(scan_data), 32'h040);
      keys = 12'h000;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
